// File: rtl/window_feed_ctrl_if.sv
// Column-load command bus toward the vertical window register plus the
// window valid/ready handshake toward the select array.
interface window_feed_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 10
);
    logic                  vr_enable;
    logic                  vr_in_select;
    logic                  vr_shift_mod;
    logic                  vr_feature_en_0;
    logic                  vr_feature_en_1;
    logic                  vr_shift_done;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  win_valid;
    logic                  win_ready;
    logic [CNT_WIDTH-1:0]  win_idx;

    modport master (
        output vr_enable, vr_in_select, vr_shift_mod, rd_addr, win_valid, win_idx,
        input  vr_feature_en_0, vr_feature_en_1, vr_shift_done, win_ready
    );

    modport slave (
        input  vr_enable, vr_in_select, vr_shift_mod, rd_addr, win_valid, win_idx,
        output vr_feature_en_0, vr_feature_en_1, vr_shift_done, win_ready
    );
endinterface

// File: rtl/window_feed_ctrl.sv
// Row sequencer for the vertical window register: one full K-column load, then
// single-column shifts, presenting each stable window through valid/ready.
module window_feed_ctrl #(
    parameter int TN          = 4,
    parameter int KERNEL_SIZE = 5,
    parameter int ADDR_WIDTH  = 10,
    parameter int CNT_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bank_sel,
    input  logic [ADDR_WIDTH-1:0] col_base,
    input  logic [CNT_WIDTH-1:0]  row_cols,
    output logic                  busy,
    output logic                  done,
    window_feed_ctrl_if.master    bus
);

    // The window register owns the K-column timing; these only guard against nonsense sizes.
    if (KERNEL_SIZE < 1 || TN < 1) begin : g_param_check
        $error("window_feed_ctrl: KERNEL_SIZE and TN must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_PRESENT,
        ST_SHIFT,
        ST_FIN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] row_cols_q;
    logic                 last_win;
    logic                 col_strobe;
    logic                 row_start;

    assign last_win   = (bus.win_idx == row_cols_q - CNT_WIDTH'(1));
    assign col_strobe = bus.vr_in_select ? bus.vr_feature_en_1 : bus.vr_feature_en_0;
    assign row_start  = (state == ST_IDLE) && start;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (start) state_next = (row_cols == '0) ? ST_FIN : ST_LOAD;
            ST_LOAD:    state_next = ST_WAIT;
            ST_SHIFT:   state_next = ST_WAIT;
            ST_WAIT:    if (bus.vr_shift_done) state_next = ST_PRESENT;
            ST_PRESENT: if (bus.win_ready) state_next = last_win ? ST_FIN : ST_SHIFT;
            ST_FIN:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state_next so each one is a flop aligned with its state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            row_cols_q       <= '0;
            bus.vr_enable    <= 1'b0;
            bus.vr_in_select <= 1'b0;
            bus.vr_shift_mod <= 1'b0;
            bus.rd_addr      <= '0;
            bus.win_valid    <= 1'b0;
            bus.win_idx      <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state         <= state_next;
            bus.vr_enable <= (state_next == ST_LOAD) || (state_next == ST_SHIFT);
            bus.vr_shift_mod <= (state_next == ST_SHIFT);
            bus.win_valid <= (state_next == ST_PRESENT);
            busy          <= (state_next != ST_IDLE) && (state_next != ST_FIN);
            done          <= (state_next == ST_FIN);

            if (row_start) begin
                bus.vr_in_select <= bank_sel;
                bus.rd_addr      <= col_base;
                row_cols_q       <= row_cols;
                bus.win_idx      <= '0;
            end else begin
                // Strobes from the bank not selected for this row belong to someone else.
                if (state != ST_IDLE && col_strobe)
                    bus.rd_addr <= bus.rd_addr + ADDR_WIDTH'(1);
                if (state == ST_PRESENT && bus.win_ready && !last_win)
                    bus.win_idx <= bus.win_idx + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_window_feed_ctrl.sv
// Directed bench for window_feed_ctrl with a behavioural window-register responder.
module tb_window_feed_ctrl;

    localparam int K  = 5;
    localparam int AW = 10;
    localparam int CW = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic          bank_sel;
    logic [AW-1:0] col_base;
    logic [CW-1:0] row_cols;
    logic          busy;
    logic          done;

    window_feed_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    window_feed_ctrl #(
        .TN(4), .KERNEL_SIZE(K), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bank_sel(bank_sel),
        .col_base(col_base), .row_cols(row_cols), .busy(busy), .done(done),
        .bus(bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic resp_strobe;
    logic inject;
    logic toggle;
    logic noise;

    // Responder strobes the latched bank; the other bank carries optional noise.
    assign noise = inject & toggle;
    assign bus.vr_feature_en_0 = bus.vr_in_select ? noise : resp_strobe;
    assign bus.vr_feature_en_1 = bus.vr_in_select ? resp_strobe : noise;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        toggle = 1'b0;
        forever @(posedge clk) toggle = ~toggle;
    end

    // Window register model: load -> K strobes then done two cycles later; shift -> 1 strobe.
    initial begin
        int ncols;
        resp_strobe       = 1'b0;
        bus.vr_shift_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.vr_enable === 1'b1) begin
                ncols = bus.vr_shift_mod ? 1 : K;
                for (int i = 0; i < ncols; i++) begin
                    @(negedge clk);
                    resp_strobe = 1'b1;
                end
                @(negedge clk);
                resp_strobe = 1'b0;
                @(negedge clk);
                bus.vr_shift_done = 1'b1;
                @(negedge clk);
                bus.vr_shift_done = 1'b0;
            end
        end
    end

    int loads = 0;
    int shifts = 0;
    int dones = 0;
    logic [CW-1:0] acc_q[$];

    initial begin
        forever begin
            @(posedge clk);
            if (bus.vr_enable === 1'b1 && bus.vr_shift_mod === 1'b0) loads++;
            if (bus.vr_enable === 1'b1 && bus.vr_shift_mod === 1'b1) shifts++;
            if (done === 1'b1) dones++;
            if (bus.win_valid === 1'b1 && bus.win_ready === 1'b1) acc_q.push_back(bus.win_idx);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic b, input logic [AW-1:0] base, input logic [CW-1:0] n);
        @(negedge clk);
        start = 1'b1; bank_sel = b; col_base = base; row_cols = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL %s_done: no done pulse within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.vr_enable, bus.vr_in_select, bus.vr_shift_mod, bus.win_valid, busy, done} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000",
                     {bus.vr_enable, bus.vr_in_select, bus.vr_shift_mod, bus.win_valid, busy, done});
        end
        vectors++;
        if (bus.rd_addr !== '0 || bus.win_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: rd_addr %0d win_idx %0d want 0 0", bus.rd_addr, bus.win_idx);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        @(negedge clk);
        start = 1'b1; bank_sel = 1'b0; col_base = 10'd100; row_cols = 10'd1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                vectors++;
                if ({bus.vr_enable, bus.vr_shift_mod, busy} !== 3'b101) begin
                    miscompares++;
                    $display("FAIL single_c1: enable/shift_mod/busy got %b want 101",
                             {bus.vr_enable, bus.vr_shift_mod, busy});
                end
            end
            if (k == 2) begin
                vectors++;
                if (bus.vr_enable !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_c2_enable: got %b want 0", bus.vr_enable);
                end
            end
            if (k == 8) begin
                vectors++;
                if (bus.win_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_c8_valid: got %b want 0", bus.win_valid);
                end
            end
            if (k == 9) begin
                vectors++;
                if (bus.win_valid !== 1'b1 || bus.win_idx !== 10'd0) begin
                    miscompares++;
                    $display("FAIL single_c9: valid %b idx %0d want 1 0", bus.win_valid, bus.win_idx);
                end
            end
            if (k == 10) begin
                vectors++;
                if ({done, busy, bus.win_valid} !== 3'b100 || bus.rd_addr !== 10'd105) begin
                    miscompares++;
                    $display("FAIL single_c10: done/busy/valid %b rd_addr %0d want 100 105",
                             {done, busy, bus.win_valid}, bus.rd_addr);
                end
            end
            if (k == 11) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL single_c11_done: got %b want 0", done);
                end
            end
        end
    endtask

    task automatic test_row_bank1;
        int l0 = loads, s0 = shifts, a0 = acc_q.size();
        inject = 1'b1;
        pulse_start(1'b1, 10'd0, 10'd4);
        wait_done(200, "row4");
        inject = 1'b0;
        vectors++;
        if (loads - l0 != 1 || shifts - s0 != 3) begin
            miscompares++;
            $display("FAIL row4_pulses: loads %0d shifts %0d want 1 3", loads - l0, shifts - s0);
        end
        vectors++;
        if (bus.rd_addr !== 10'd8 || bus.vr_in_select !== 1'b1) begin
            miscompares++;
            $display("FAIL row4_addr: rd_addr %0d in_select %b want 8 1", bus.rd_addr, bus.vr_in_select);
        end
        vectors++;
        if (acc_q.size() - a0 != 4) begin
            miscompares++;
            $display("FAIL row4_accepts: got %0d want 4", acc_q.size() - a0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (acc_q[a0 + i] !== 10'(i)) begin
                    miscompares++;
                    $display("FAIL row4_idx%0d: got %0d want %0d", i, acc_q[a0 + i], i);
                end
            end
        end
    endtask

    task automatic test_back_pressure;
        int s0 = shifts;
        int bad = 0;
        bit found = 1'b0;
        bus.win_ready = 1'b1;
        pulse_start(1'b0, 10'd10, 10'd4);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.win_valid === 1'b1 && bus.win_idx === 10'd2) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL bp_window2: window 2 never presented");
        end
        bus.win_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (bus.win_valid !== 1'b1 || bus.win_idx !== 10'd2 || bus.vr_enable !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL bp_hold: %0d stall cycles lost valid/idx or issued enable, want 0", bad);
        end
        bus.win_ready = 1'b1;
        wait_done(200, "bp");
        vectors++;
        if (bus.rd_addr !== 10'd18 || shifts - s0 != 3) begin
            miscompares++;
            $display("FAIL bp_end: rd_addr %0d shifts %0d want 18 3", bus.rd_addr, shifts - s0);
        end
    endtask

    task automatic test_zero_and_busy_start;
        int d = 0, e = 0;
        int l0, s0, a0, d0;
        @(negedge clk);
        start = 1'b1; bank_sel = 1'b1; col_base = 10'd300; row_cols = 10'd0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (done === 1'b1 && k <= 2) d++;
            if (bus.vr_enable !== 1'b0) e++;
        end
        vectors++;
        if (d != 1 || e != 0) begin
            miscompares++;
            $display("FAIL zero_row: done pulses %0d enables %0d want 1 0", d, e);
        end
        l0 = loads; s0 = shifts; a0 = acc_q.size(); d0 = dones;
        pulse_start(1'b0, 10'd200, 10'd2);
        repeat (3) @(negedge clk);
        start = 1'b1; bank_sel = 1'b1; col_base = 10'd500; row_cols = 10'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(200, "busy_start");
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.rd_addr !== 10'd206 || bus.vr_in_select !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_start_addr: rd_addr %0d in_select %b want 206 0", bus.rd_addr, bus.vr_in_select);
        end
        vectors++;
        if (loads - l0 != 1 || shifts - s0 != 1 || acc_q.size() - a0 != 2 || dones - d0 != 1) begin
            miscompares++;
            $display("FAIL busy_start_counts: loads %0d shifts %0d accepts %0d dones %0d want 1 1 2 1",
                     loads - l0, shifts - s0, acc_q.size() - a0, dones - d0);
        end
    endtask

    task automatic test_wrap;
        int a0 = acc_q.size();
        pulse_start(1'b1, 10'd1020, 10'd3);
        wait_done(200, "wrap");
        vectors++;
        if (bus.rd_addr !== 10'd3 || acc_q.size() - a0 != 3) begin
            miscompares++;
            $display("FAIL wrap: rd_addr %0d accepts %0d want 3 3", bus.rd_addr, acc_q.size() - a0);
        end
    endtask

    task automatic test_async_reset;
        int d0;
        bit found = 1'b0;
        bus.win_ready = 1'b0;
        pulse_start(1'b1, 10'd50, 10'd2);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.win_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL areset_present: never reached PRESENT");
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bus.win_valid, busy, bus.vr_enable, bus.vr_in_select} !== 4'b0 || bus.rd_addr !== '0) begin
            miscompares++;
            $display("FAIL areset_async: valid/busy/enable/in_select %b rd_addr %0d want 0000 0",
                     {bus.win_valid, busy, bus.vr_enable, bus.vr_in_select}, bus.rd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        d0 = dones;
        repeat (3) @(negedge clk);
        vectors++;
        if (dones != d0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_idle: done pulses %0d busy %b want 0 0", dones - d0, busy);
        end
        bus.win_ready = 1'b1;
        pulse_start(1'b0, 10'd7, 10'd1);
        wait_done(100, "areset_restart");
        vectors++;
        if (bus.rd_addr !== 10'd12 || bus.win_idx !== 10'd0) begin
            miscompares++;
            $display("FAIL areset_restart: rd_addr %0d win_idx %0d want 12 0", bus.rd_addr, bus.win_idx);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bank_sel = 1'b0;
        col_base = '0;
        row_cols = '0;
        inject = 1'b0;
        bus.win_ready = 1'b1;

        test_reset();
        test_single();
        test_row_bank1();
        test_back_pressure();
        test_zero_and_busy_start();
        test_wrap();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
